// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams (attr, coeff) pairs from local banks into mac2 and captures the dot product.
// Latency: done pulses in cycle 2+len+MAC_LAT after the start cycle (cycle 1 when len=0).
// Flow control: none; start and bank writes are ignored while busy. MACSEQ_PERF_CNT_EN adds cycle_cnt.
module mac_operand_sequencer #(
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_rst,
  input  logic [31:0]   mac_acc,
  output logic [31:0]   result,
  output logic          result_valid,
  output logic          done
`ifdef MACSEQ_PERF_CNT_EN
  ,
  output logic [15:0]   cycle_cnt
`endif
);

  // Drain counter only needs to hold MAC_LAT-1; keep at least one bit.
  localparam int            DCW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(MAC_LAT - 1);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  idx;
  logic [AW:0]    len_q;
  logic [AW:0]    len_eff;
  logic [DCW-1:0] drain_cnt;
  logic           start_ok;
  logic           last_pair;
  logic           drain_last;
  logic           wr_ok;

  logic [DW-1:0] attr_mem  [DEPTH];
  logic [DW-1:0] coeff_mem [DEPTH];

  // Requested lengths beyond the bank size are clamped to a full bank.
  assign len_eff    = (len > DEPTH_L) ? DEPTH_L : len;
  assign start_ok   = start && (state == S_IDLE);
  assign last_pair  = ({1'b0, idx} == (len_q - (AW+1)'(1)));
  assign drain_last = (drain_cnt == '0);
  assign wr_ok      = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE, len=0 short-cuts to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len_eff == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (last_pair)  state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-state outputs: the MAC is held in reset while idle/clearing, operands only driven while streaming.
  always_comb begin
    busy    = 1'b0;
    mac_rst = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    done    = 1'b0;
    case (state)
      S_IDLE:  mac_rst = 1'b1;
      S_CLEAR: begin
        busy    = 1'b1;
        mac_rst = 1'b1;
      end
      S_STREAM: begin
        busy  = 1'b1;
        mac_a = attr_mem[idx];
        mac_b = coeff_mem[idx];
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: mac_rst = 1'b1;
    endcase
  end

  // Sequencing datapath: length latch, stream index, drain countdown and result capture.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      idx          <= '0;
      len_q        <= '0;
      drain_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q        <= len_eff;
            result_valid <= 1'b0;
            if (len_eff == '0) result <= '0;
          end
        end
        S_CLEAR: idx <= '0;
        S_STREAM: begin
          idx <= idx + AW'(1);
          if (last_pair) drain_cnt <= DRAIN_INIT;
        end
        S_DRAIN: begin
          if (drain_last) result    <= mac_acc;
          else            drain_cnt <= drain_cnt - DCW'(1);
        end
        S_DONE:  result_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // Bank writes; banks are deliberately not reset so vectors survive an abort.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) coeff_mem[wr_addr] <= wr_data;
      else        attr_mem[wr_addr]  <= wr_data;
    end
  end

`ifdef MACSEQ_PERF_CNT_EN
  // Busy-cycle counter: restarts on an accepted start, saturates, holds once the operation ends.
  always_ff @(posedge clk) begin
    if (rst_in)                            cycle_cnt <= '0;
    else if (start_ok)                     cycle_cnt <= '0;
    else if (busy && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
  end
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer with behavioural mac2 models (MAC_LAT=1 and MAC_LAT=3).
// Table-driven dot products plus hand-written sequences for ignored start/write, abort and deep drain.
// Expected results go through a scoreboard queue and are popped on each done pulse.
`timescale 1ns/1ps
module tb_mac_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // MAC_LAT=1 instance
  logic        rst_in, wr_en, wr_sel, start;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  len;
  logic        busy, mac_rst, result_valid, done;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_acc, result;
`ifdef MACSEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt, l3_cycle_cnt;
`endif

  // MAC_LAT=3 instance
  logic        l3_rst, l3_wr_en, l3_wr_sel, l3_start;
  logic [2:0]  l3_wr_addr;
  logic [15:0] l3_wr_data;
  logic [3:0]  l3_len;
  logic        l3_busy, l3_mac_rst, l3_result_valid, l3_done;
  logic [15:0] l3_mac_a, l3_mac_b;
  logic [31:0] l3_acc, l3_result, l3_p1, l3_p2;

  mac_operand_sequencer dut (
    .clk(clk), .rst_in(rst_in), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .start(start), .busy(busy), .mac_a(mac_a), .mac_b(mac_b),
    .mac_rst(mac_rst), .mac_acc(mac_acc), .result(result), .result_valid(result_valid),
    .done(done)
`ifdef MACSEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  mac_operand_sequencer #(.MAC_LAT(3)) dut_l3 (
    .clk(clk), .rst_in(l3_rst), .wr_en(l3_wr_en), .wr_sel(l3_wr_sel), .wr_addr(l3_wr_addr),
    .wr_data(l3_wr_data), .len(l3_len), .start(l3_start), .busy(l3_busy), .mac_a(l3_mac_a),
    .mac_b(l3_mac_b), .mac_rst(l3_mac_rst), .mac_acc(l3_acc), .result(l3_result),
    .result_valid(l3_result_valid), .done(l3_done)
`ifdef MACSEQ_PERF_CNT_EN
    , .cycle_cnt(l3_cycle_cnt)
`endif
  );

  // Behavioural mac2, one cycle from operands to accumulator.
  always @(posedge clk) begin
    if (mac_rst) mac_acc <= 32'd0;
    else         mac_acc <= mac_acc + 32'(mac_a) * 32'(mac_b);
  end

  // Behavioural mac2 with a two-stage product pipeline: three cycles operands to accumulator.
  always @(posedge clk) begin
    if (l3_mac_rst) begin
      l3_p1  <= 32'd0;
      l3_p2  <= 32'd0;
      l3_acc <= 32'd0;
    end else begin
      l3_p1  <= 32'(l3_mac_a) * 32'(l3_mac_b);
      l3_p2  <= l3_p1;
      l3_acc <= l3_acc + l3_p2;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[2:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_banks(input logic [0:7][15:0] av, input logic [0:7][15:0] bv);
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, av[i]);
      wr(1'b1, i, bv[i]);
    end
  endtask

  // Start a dot product in cycle 0 and check every output cycle by cycle until two cycles after done.
  // inj_start / inj_wr (-1 = none) assert a stray start / attr[0] write in that cycle.
  task automatic run_dot(input string nm, input int ln, input logic [0:7][15:0] av,
                         input logic [0:7][15:0] bv, input logic [31:0] exp, input int dc,
                         input int inj_start, input int inj_wr);
    int eff;
    logic in_stream, exp_busy, exp_rst;
    logic [15:0] exp_a, exp_b;
    eff = (ln > 8) ? 8 : ln;
    @(negedge clk);
    start = 1'b1; len = ln[3:0];
    exp_q.push_back(exp);
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge clk);
      in_stream = (eff > 0) && (c >= 2) && (c <= 1 + eff);
      exp_busy  = (eff > 0) && (c < dc);
      exp_rst   = (c > dc) || (c == 1 && eff > 0);
      exp_a = '0; exp_b = '0;
      if (in_stream) begin
        exp_a = av[c-2];
        exp_b = bv[c-2];
      end
      chk({nm, "_busy"}, busy, exp_busy);
      chk({nm, "_done"}, done, c == dc);
      chk({nm, "_mac_rst"}, mac_rst, exp_rst);
      chk({nm, "_mac_a"}, mac_a, exp_a);
      chk({nm, "_mac_b"}, mac_b, exp_b);
      if (c == 1 && eff > 0) chk({nm, "_valid_drop"}, result_valid, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) chk({nm, "_unexpected_done"}, 32'd1, 32'd0);
        else                   chk({nm, "_result"}, result, exp_q.pop_front());
      end
      if (c == dc + 1) begin
        chk({nm, "_valid"}, result_valid, 1'b1);
        chk({nm, "_result_hold"}, result, exp);
`ifdef MACSEQ_PERF_CNT_EN
        chk({nm, "_cycle_cnt"}, cycle_cnt, (eff > 0) ? 32'(eff + 2) : 32'd0);
`endif
      end
      // drive this cycle's inputs
      start = (c == inj_start);
      if (c == inj_start) len = 4'd3;
      wr_en = (c == inj_wr);
      if (c == inj_wr) begin
        wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 16'd999;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    chk({nm, "_sb_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    int               ln;
    logic [0:7][15:0] a;
    logic [0:7][15:0] b;
    logic [31:0]      exp;
    int               dc;
  } vec_t;

  vec_t tbl [6];
  logic [0:7][15:0] ra, rb;

  initial begin
    tbl[0] = '{5, {16'd49, 16'd30, 16'd14, 16'd47, 16'd32, 16'd0, 16'd0, 16'd0},
                  {16'd10, 16'd10, 16'd0, 16'd10, 16'd10, 16'd0, 16'd0, 16'd0}, 32'd1580, 8};
    tbl[1] = '{3, {16'd49, 16'd30, 16'd13, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  {16'd10, 16'd10, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'd920, 6};
    tbl[2] = '{0, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                  {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 32'd0, 1};
    tbl[3] = '{8, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                  {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 32'd204, 11};
    tbl[4] = '{15, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                   {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 32'd204, 11};
    tbl[5] = '{1, {16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  {16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'hFFFE0001, 4};

    rst_in = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0;
    l3_rst = 1'b1; l3_wr_en = 1'b0; l3_wr_sel = 1'b0; l3_wr_addr = '0; l3_wr_data = '0;
    l3_len = '0; l3_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0; l3_rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_mac_rst", mac_rst, 1'b1);
    chk("rst_mac_a", mac_a, 16'd0);
    chk("rst_mac_b", mac_b, 16'd0);
`ifdef MACSEQ_PERF_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 16'd0);
`endif

    for (int r = 0; r < 6; r++) begin
      load_banks(tbl[r].a, tbl[r].b);
      run_dot($sformatf("row%0d", r), tbl[r].ln, tbl[r].a, tbl[r].b, tbl[r].exp, tbl[r].dc, -1, -1);
    end

    // stray start and write while streaming are ignored; rerun shows the bank is intact
    ra = tbl[0].a; rb = tbl[0].b;
    load_banks(ra, rb);
    run_dot("midstream", 5, ra, rb, 32'd1580, 8, 3, 4);
    run_dot("reuse", 5, ra, rb, 32'd1580, 8, -1, -1);
    // start presented in the DONE cycle is ignored
    run_dot("start_in_done", 5, ra, rb, 32'd1580, 8, 8, -1);

    // reset pulsed during DRAIN (cycle 7 for len=5, MAC_LAT=1)
    @(negedge clk);
    start = 1'b1; len = 4'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("abort_done", done, 1'b0);
      if (c == 7) chk("abort_in_drain", busy, 1'b1);
      if (c == 8) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 32'd0);
        chk("abort_valid", result_valid, 1'b0);
        chk("abort_mac_rst", mac_rst, 1'b1);
      end
      start  = 1'b0;
      rst_in = (c == 7);
    end
    rst_in = 1'b0;
    run_dot("after_abort", 5, ra, rb, 32'd1580, 8, -1, -1);

    // MAC_LAT=3: {1,2}.{3,4}; CLEAR 1, STREAM 2-3, DRAIN 4-6, DONE 7
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      l3_wr_en = 1'b1; l3_wr_sel = 1'b0; l3_wr_addr = 3'(i); l3_wr_data = 16'(i + 1);
      @(negedge clk);
      l3_wr_sel = 1'b1; l3_wr_data = 16'(i + 3);
      @(negedge clk);
      l3_wr_en = 1'b0;
    end
    @(negedge clk);
    l3_start = 1'b1; l3_len = 4'd2;
    exp_q.push_back(32'd11);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      l3_start = 1'b0;
      chk("l3_done", l3_done, c == 7);
      chk("l3_busy", l3_busy, (c >= 1) && (c <= 6));
      if (c >= 4 && c <= 6) begin
        chk("l3_drain_mac_rst", l3_mac_rst, 1'b0);
        chk("l3_drain_mac_a", l3_mac_a, 16'd0);
      end
      if (l3_done) begin
        if (exp_q.size() == 0) chk("l3_unexpected_done", 32'd1, 32'd0);
        else                   chk("l3_result", l3_result, exp_q.pop_front());
      end
      if (c == 8) begin
        chk("l3_valid", l3_result_valid, 1'b1);
`ifdef MACSEQ_PERF_CNT_EN
        chk("l3_cycle_cnt", l3_cycle_cnt, 16'd6);
`endif
      end
    end
    chk("l3_sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
